// File: rtl/spi_follower_adc.sv
// SPI follower emulating an 8-channel serial ADC: decodes start bit + channel, returns held sample MSB first.
// Latency: 3 clk pin-to-strobe, Dout 4 clk after SCLK fall, Dout_oe drop 3 clk after CS rise; no backpressure.
module spi_follower_adc #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 8,
    parameter int CH_BITS    = 3
) (
    input  logic                           CLK_50MHz,
    input  logic                           RESET,
    input  logic                           CLKsample,
    input  logic                           Din,
    input  logic                           CS,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data,
    output logic                           Dout,
    output logic                           Dout_oe,
    output logic [CH_BITS-1:0]             channel,
    output logic                           frame_done,
    output logic                           frame_abort
);

    localparam int CNT_MAX = (DATA_WIDTH > CH_BITS) ? DATA_WIDTH : CH_BITS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CH_LAST   = CNT_W'(CH_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_GET_CH,
        S_NULL,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                  state;
    logic [1:0]              sclk_sync;
    logic [1:0]              din_sync;
    logic [1:0]              cs_sync;
    logic                    sclk_prev;
    logic                    rise_stb;
    logic                    fall_stb;
    logic                    din_smp;
    logic                    cs_hi;
    logic [CH_BITS-1:0]      ch_shift;
    logic [CH_BITS-1:0]      ch_next;
    logic [CNT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]   sample_sr;
    logic [DATA_WIDTH-1:0]   slices [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slice
        assign slices[g] = ch_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign cs_hi   = cs_sync[1];
    assign ch_next = CH_BITS'({ch_shift, din_smp});

    // Din is registered alongside the strobe so the FSM sees the value present at the SCLK rise.
    always_ff @(posedge CLK_50MHz or posedge RESET) begin
        if (RESET) begin
            sclk_sync <= '0;
            din_sync  <= '0;
            cs_sync   <= '0;
            sclk_prev <= 1'b0;
            rise_stb  <= 1'b0;
            fall_stb  <= 1'b0;
            din_smp   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], CLKsample};
            din_sync  <= {din_sync[0], Din};
            cs_sync   <= {cs_sync[0], CS};
            sclk_prev <= sclk_sync[1];
            rise_stb  <= sclk_sync[1] & ~sclk_prev;
            fall_stb  <= ~sclk_sync[1] & sclk_prev;
            din_smp   <= din_sync[1];
        end
    end

    always_ff @(posedge CLK_50MHz or posedge RESET) begin
        if (RESET) begin
            state       <= S_IDLE;
            Dout        <= 1'b0;
            Dout_oe     <= 1'b0;
            channel     <= '0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            ch_shift    <= '0;
            bit_cnt     <= '0;
            sample_sr   <= '0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            // CS release outranks any strobe arriving in the same cycle.
            if (state != S_IDLE && cs_hi) begin
                state       <= S_IDLE;
                Dout        <= 1'b0;
                Dout_oe     <= 1'b0;
                frame_done  <= (state == S_DONE);
                frame_abort <= (state inside {S_GET_CH, S_NULL, S_SHIFT});
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!cs_hi) begin
                            state <= S_WAIT_START;
                        end
                    end
                    S_WAIT_START: begin
                        if (rise_stb && din_smp) begin
                            state    <= S_GET_CH;
                            bit_cnt  <= '0;
                            ch_shift <= '0;
                        end
                    end
                    S_GET_CH: begin
                        if (rise_stb) begin
                            ch_shift <= ch_next;
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CH_LAST) begin
                                channel   <= ch_next;
                                sample_sr <= slices[ch_next];
                                state     <= S_NULL;
                            end
                        end
                    end
                    S_NULL: begin
                        if (fall_stb) begin
                            Dout_oe <= 1'b1;
                            Dout    <= 1'b0;
                            bit_cnt <= '0;
                            state   <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        if (fall_stb) begin
                            Dout      <= sample_sr[DATA_WIDTH-1];
                            sample_sr <= sample_sr << 1;
                            bit_cnt   <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == DATA_LAST) begin
                                state <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        if (fall_stb) begin
                            Dout <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
